// File: rtl/trng_div_sequencer.sv
// Steps a divisor table into the TRNG sampling divider, mirroring its counter so changes land on toggle boundaries.
// Tick 1 cycle after counter match; a completed slot holds sample_valid/sample_slot until sample_ready, counting frozen.
module trng_div_sequencer #(
  parameter int DEPTH = 4,
  parameter int SW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_addr,
  input  logic [7:0]    cfg_data,
  input  logic [7:0]    dwell,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [7:0]    divisor,
  output logic          tick,
  output logic          sample_valid,
  output logic [SW-1:0] sample_slot,
  input  logic          sample_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    tbl_q [DEPTH];
  logic [7:0]    divisor_q, divisor_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tog_q, tog_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] sslot_q, sslot_d;
  logic          tick_q, tick_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic [7:0]    dwell_eff;
  logic [SW-1:0] slot_nxt;
  logic          cnt_match;
  logic          dwell_hit;
  logic          pass_end;

  assign dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;
  assign slot_nxt  = slot_q + SW'(1);
  assign cnt_match = (cnt_q == divisor_q);
  assign dwell_hit = ((tog_q + 8'd1) == dwell_eff);
  assign pass_end  = !loop && (sslot_q == SW'(DEPTH - 1));

  // Table writes are independent of the sequencer state; a loaded divisor is a private copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= 8'd0;
      end
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop)                        state_d = S_IDLE;
        else if (cnt_match && dwell_hit) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop)              state_d = S_IDLE;
        else if (sample_ready) state_d = pass_end ? S_IDLE : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    slot_d    = slot_q;
    sslot_d   = sslot_q;
    tick_d    = 1'b0;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          divisor_d = tbl_q[0];
          slot_d    = '0;
          cnt_d     = 8'd0;
          tog_d     = 8'd0;
        end
      end
      S_RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          tog_d   = 8'd0;
        end else if (!cnt_match) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d  = 8'd0;
          tick_d = 1'b1;
          if (dwell_hit) begin
            tog_d     = 8'd0;
            valid_d   = 1'b1;
            sslot_d   = slot_q;
            slot_d    = slot_nxt;
            divisor_d = tbl_q[slot_nxt];
          end else begin
            tog_d = tog_q + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (stop) begin
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          tog_d   = 8'd0;
        end else if (sample_ready) begin
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          done_d  = pass_end;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_q <= 8'd0;
      cnt_q     <= 8'd0;
      tog_q     <= 8'd0;
      slot_q    <= '0;
      sslot_q   <= '0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      slot_q    <= slot_d;
      sslot_q   <= sslot_d;
      tick_q    <= tick_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign divisor      = divisor_q;
  assign tick         = tick_q;
  assign sample_valid = valid_q;
  assign sample_slot  = sslot_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule
